// File: rtl/sine_pwm_seq_ctrl_if.sv
// Control/status bundle between the run-state sequencer and its host/datapath.
// The master side drives requests and targets; the slave side is the sequencer.
interface sine_pwm_seq_ctrl_if #(
    parameter int unsigned TW_WIDTH  = 16,
    parameter int unsigned AMP_WIDTH = 8
) ();

    logic                 start;
    logic                 stop;
    logic                 fault;
    logic                 fault_clr;
    logic                 carrier_wrap;
    logic [TW_WIDTH-1:0]  target_tw;
    logic [AMP_WIDTH-1:0] target_amp;

    logic                 pwm_en;
    logic [TW_WIDTH-1:0]  tune_word;
    logic [AMP_WIDTH-1:0] amp;
    logic                 cfg_update;
    logic                 busy;
    logic                 fault_latched;
    logic [2:0]           state;

    modport master (
        output start,
        output stop,
        output fault,
        output fault_clr,
        output carrier_wrap,
        output target_tw,
        output target_amp,
        input  pwm_en,
        input  tune_word,
        input  amp,
        input  cfg_update,
        input  busy,
        input  fault_latched,
        input  state
    );

    modport slave (
        input  start,
        input  stop,
        input  fault,
        input  fault_clr,
        input  carrier_wrap,
        input  target_tw,
        input  target_amp,
        output pwm_en,
        output tune_word,
        output amp,
        output cfg_update,
        output busy,
        output fault_latched,
        output state
    );

endinterface

// File: rtl/sine_pwm_seq_ctrl.sv
// Run-state sequencer for the sine-PWM datapath: soft start/stop ramps of tuning word
// and amplitude, aligned to carrier wraps, with latched fault shutdown.
module sine_pwm_seq_ctrl #(
    parameter int unsigned TW_WIDTH  = 16,
    parameter int unsigned AMP_WIDTH = 8,
    parameter int unsigned TW_STEP   = 16,
    parameter int unsigned AMP_STEP  = 8,
    parameter int unsigned RAMP_DIV  = 4
) (
    input logic                clk,
    input logic                rst,
    sine_pwm_seq_ctrl_if.slave bus
);

    localparam int unsigned CntW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned TwGW    = TW_WIDTH + 1;
    localparam int unsigned AmpGW   = AMP_WIDTH + 1;
    localparam logic [CntW-1:0]    CntLast  = CntW'(RAMP_DIV - 1);
    localparam logic [CntW-1:0]    CntOne   = CntW'(1);
    localparam logic [TW_WIDTH:0]  TwStepG  = TwGW'(TW_STEP);
    localparam logic [AMP_WIDTH:0] AmpStepG = AmpGW'(AMP_STEP);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRampUp   = 3'd1,
        StRun      = 3'd2,
        StRampDown = 3'd3,
        StFault    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [TW_WIDTH-1:0]  tw_q, tw_d;
    logic [AMP_WIDTH-1:0] amp_q, amp_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 cfg_q, cfg_d;
    logic                 pwm_en_q, busy_q, fault_q;

    logic                 tick;
    logic [TW_WIDTH-1:0]  goal_tw, next_tw;
    logic [AMP_WIDTH-1:0] goal_amp, next_amp;

    // One step toward goal, clamped at goal; the guard bit catches both overshoot directions.
    function automatic logic [TW_WIDTH-1:0] step_tw(input logic [TW_WIDTH-1:0] cur,
                                                    input logic [TW_WIDTH-1:0] goal);
        logic [TW_WIDTH:0]   cur_g, goal_g, sum, diff;
        logic [TW_WIDTH-1:0] res;
        cur_g  = {1'b0, cur};
        goal_g = {1'b0, goal};
        sum    = cur_g + TwStepG;
        diff   = cur_g - TwStepG;
        res    = cur;
        if (cur_g < goal_g) begin
            res = (sum > goal_g) ? goal : sum[TW_WIDTH-1:0];
        end else if (cur_g > goal_g) begin
            res = (diff[TW_WIDTH] || (diff < goal_g)) ? goal : diff[TW_WIDTH-1:0];
        end
        return res;
    endfunction

    function automatic logic [AMP_WIDTH-1:0] step_amp(input logic [AMP_WIDTH-1:0] cur,
                                                      input logic [AMP_WIDTH-1:0] goal);
        logic [AMP_WIDTH:0]   cur_g, goal_g, sum, diff;
        logic [AMP_WIDTH-1:0] res;
        cur_g  = {1'b0, cur};
        goal_g = {1'b0, goal};
        sum    = cur_g + AmpStepG;
        diff   = cur_g - AmpStepG;
        res    = cur;
        if (cur_g < goal_g) begin
            res = (sum > goal_g) ? goal : sum[AMP_WIDTH-1:0];
        end else if (cur_g > goal_g) begin
            res = (diff[AMP_WIDTH] || (diff < goal_g)) ? goal : diff[AMP_WIDTH-1:0];
        end
        return res;
    endfunction

    // Goal follows the state being left, so a wrap coinciding with a transition uses old goal.
    always_comb begin
        tick     = bus.carrier_wrap && (cnt_q == CntLast);
        goal_tw  = (state_q == StRampDown) ? '0 : bus.target_tw;
        goal_amp = (state_q == StRampDown) ? '0 : bus.target_amp;
        next_tw  = step_tw(tw_q, goal_tw);
        next_amp = step_amp(amp_q, goal_amp);
    end

    always_comb begin
        state_d = state_q;
        tw_d    = tw_q;
        amp_d   = amp_q;
        cnt_d   = cnt_q;
        cfg_d   = 1'b0;

        if (bus.fault) begin
            state_d = StFault;
            tw_d    = '0;
            amp_d   = '0;
            cnt_d   = '0;
            cfg_d   = (tw_q != '0) || (amp_q != '0);
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start && !bus.stop) begin
                        state_d = StRampUp;
                        cnt_d   = '0;
                    end
                end

                StRampUp, StRun, StRampDown: begin
                    if (bus.carrier_wrap) begin
                        cnt_d = tick ? '0 : (cnt_q + CntOne);
                    end
                    if (tick) begin
                        tw_d  = next_tw;
                        amp_d = next_amp;
                        cfg_d = (next_tw != tw_q) || (next_amp != amp_q);
                    end

                    case (state_q)
                        StRampUp: begin
                            if (bus.stop) begin
                                state_d = StRampDown;
                            end else if ((tw_q == bus.target_tw) && (amp_q == bus.target_amp)) begin
                                state_d = StRun;
                            end
                        end
                        StRun: begin
                            if (bus.stop) begin
                                state_d = StRampDown;
                            end
                        end
                        default: begin
                            // Leave for IDLE in the same cycle the last zero step lands.
                            if (bus.start && !bus.stop) begin
                                state_d = StRampUp;
                            end else if ((tw_d == '0) && (amp_d == '0)) begin
                                state_d = StIdle;
                            end
                        end
                    endcase
                end

                StFault: begin
                    if (bus.fault_clr) begin
                        state_d = StIdle;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            tw_q     <= '0;
            amp_q    <= '0;
            cnt_q    <= '0;
            cfg_q    <= 1'b0;
            pwm_en_q <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tw_q     <= tw_d;
            amp_q    <= amp_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            pwm_en_q <= (state_d == StRampUp) || (state_d == StRun) || (state_d == StRampDown);
            busy_q   <= (state_d == StRampUp) || (state_d == StRampDown);
            fault_q  <= (state_d == StFault);
        end
    end

    assign bus.pwm_en        = pwm_en_q;
    assign bus.tune_word     = tw_q;
    assign bus.amp           = amp_q;
    assign bus.cfg_update    = cfg_q;
    assign bus.busy          = busy_q;
    assign bus.fault_latched = fault_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_sine_pwm_seq_ctrl.sv
// Self-checking bench for sine_pwm_seq_ctrl: directed vector table, test-plan sequences,
// and randomized traffic compared every cycle against a behavioural model.
module tb_sine_pwm_seq_ctrl;

    localparam int TW_W   = 16;
    localparam int AMP_W  = 8;
    localparam int TW_ST  = 16;
    localparam int AMP_ST = 8;
    localparam int DIV    = 4;

    localparam int S_IDLE = 0;
    localparam int S_UP   = 1;
    localparam int S_RUN  = 2;
    localparam int S_DOWN = 3;
    localparam int S_FLT  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sine_pwm_seq_ctrl_if #(.TW_WIDTH(TW_W), .AMP_WIDTH(AMP_W)) bus ();

    sine_pwm_seq_ctrl #(
        .TW_WIDTH (TW_W),
        .AMP_WIDTH(AMP_W),
        .TW_STEP  (TW_ST),
        .AMP_STEP (AMP_ST),
        .RAMP_DIV (DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_st  = 0;
    int m_tw  = 0;
    int m_amp = 0;
    int m_cnt = 0;
    int m_cfg = 0;

    typedef struct {
        bit start, stop, fault, clr, wrap;
        int ttw, tamp;
        int st, tw, amp, cfg, en;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit s, bit p, bit f, bit c, bit w, int ttw, int tamp,
                                int st, int tw, int amp, int cfg, int en);
        vec_t v;
        v.start = s; v.stop = p; v.fault = f; v.clr = c; v.wrap = w;
        v.ttw = ttw; v.tamp = tamp;
        v.st = st; v.tw = tw; v.amp = amp; v.cfg = cfg; v.en = en;
        return v;
    endfunction

    function automatic int toward(int cur, int goal, int stp);
        if (cur < goal) return (cur + stp > goal) ? goal : cur + stp;
        if (cur > goal) return (cur - stp < goal) ? goal : cur - stp;
        return cur;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int  nst, ntw, namp, ncnt, ncfg, gtw, gamp;
        bit  tick;
        nst = m_st; ntw = m_tw; namp = m_amp; ncnt = m_cnt; ncfg = 0;
        if (rst) begin
            nst = S_IDLE; ntw = 0; namp = 0; ncnt = 0;
        end else if (bus.fault) begin
            ncfg = (m_tw != 0 || m_amp != 0) ? 1 : 0;
            nst = S_FLT; ntw = 0; namp = 0; ncnt = 0;
        end else if (m_st == S_FLT) begin
            if (bus.fault_clr) nst = S_IDLE;
        end else if (m_st == S_IDLE) begin
            if (bus.start && !bus.stop) begin
                nst = S_UP; ncnt = 0;
            end
        end else begin
            tick = bus.carrier_wrap && (m_cnt == DIV - 1);
            if (bus.carrier_wrap) ncnt = (m_cnt + 1) % DIV;
            if (tick) begin
                gtw  = (m_st == S_DOWN) ? 0 : int'(bus.target_tw);
                gamp = (m_st == S_DOWN) ? 0 : int'(bus.target_amp);
                ntw  = toward(m_tw, gtw, TW_ST);
                namp = toward(m_amp, gamp, AMP_ST);
                ncfg = (ntw != m_tw || namp != m_amp) ? 1 : 0;
            end
            if (m_st == S_UP) begin
                if (bus.stop) nst = S_DOWN;
                else if (m_tw == int'(bus.target_tw) && m_amp == int'(bus.target_amp)) nst = S_RUN;
            end else if (m_st == S_RUN) begin
                if (bus.stop) nst = S_DOWN;
            end else begin
                if (bus.start && !bus.stop) nst = S_UP;
                else if (ntw == 0 && namp == 0) nst = S_IDLE;
            end
        end
        m_st = nst; m_tw = ntw; m_amp = namp; m_cnt = ncnt; m_cfg = ncfg;
    endtask

    task automatic cmp_model();
        chk("m_state", int'(bus.state), m_st);
        chk("m_tune_word", int'(bus.tune_word), m_tw);
        chk("m_amp", int'(bus.amp), m_amp);
        chk("m_cfg_update", int'(bus.cfg_update), m_cfg);
        chk("m_pwm_en", int'(bus.pwm_en), (m_st >= S_UP && m_st <= S_DOWN) ? 1 : 0);
        chk("m_busy", int'(bus.busy), (m_st == S_UP || m_st == S_DOWN) ? 1 : 0);
        chk("m_fault_latched", int'(bus.fault_latched), (m_st == S_FLT) ? 1 : 0);
    endtask

    // One clock: DUT and model both see the current inputs; pulses are then dropped.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        cmp_model();
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.fault_clr    = 1'b0;
        bus.carrier_wrap = 1'b0;
    endtask

    task automatic wrap_after(int period);
        for (int i = 0; i < period - 1; i++) step();
        bus.carrier_wrap = 1'b1;
        step();
    endtask

    int up_tw[3]   = '{16, 32, 40};
    int up_amp[3]  = '{8, 16, 24};
    int dn_tw[3]   = '{24, 8, 0};
    int dn_amp[3]  = '{16, 8, 0};
    int trk_amp[3] = '{16, 8, 4};

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.fault = 1'b0; bus.fault_clr = 1'b0;
        bus.carrier_wrap = 1'b0; bus.target_tw = '0; bus.target_amp = '0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_tw", int'(bus.tune_word), 0);
        chk("rst_en", int'(bus.pwm_en), 0);
        rst = 1'b0;

        // Directed table: wrap pulses back to back, so every 4th wrap is a tick
        vecs.push_back(mk(1,0,0,0,0, 40,24, S_UP,   0, 0, 0,1));
        vecs.push_back(mk(0,0,0,0,1, 40,24, S_UP,   0, 0, 0,1));
        vecs.push_back(mk(0,0,0,0,1, 40,24, S_UP,   0, 0, 0,1));
        vecs.push_back(mk(0,0,0,0,1, 40,24, S_UP,   0, 0, 0,1));
        vecs.push_back(mk(0,0,0,0,1, 40,24, S_UP,  16, 8, 1,1));
        vecs.push_back(mk(0,1,0,0,0, 40,24, S_DOWN,16, 8, 0,1));
        vecs.push_back(mk(1,0,0,0,1, 40,24, S_UP,  16, 8, 0,1));
        vecs.push_back(mk(0,0,0,0,1, 40,24, S_UP,  16, 8, 0,1));
        vecs.push_back(mk(0,0,0,0,1, 40,24, S_UP,  16, 8, 0,1));
        vecs.push_back(mk(0,0,0,0,1, 40,24, S_UP,  32,16, 1,1));
        vecs.push_back(mk(0,0,1,0,0, 40,24, S_FLT,  0, 0, 1,0));
        vecs.push_back(mk(1,0,0,0,0, 40,24, S_FLT,  0, 0, 0,0));
        vecs.push_back(mk(0,0,1,1,0, 40,24, S_FLT,  0, 0, 0,0));
        vecs.push_back(mk(0,0,0,1,0, 40,24, S_IDLE, 0, 0, 0,0));
        vecs.push_back(mk(1,1,0,0,0, 40,24, S_IDLE, 0, 0, 0,0));
        vecs.push_back(mk(1,0,0,0,0,  0, 0, S_UP,   0, 0, 0,1));
        vecs.push_back(mk(0,0,0,0,0,  0, 0, S_RUN,  0, 0, 0,1));
        vecs.push_back(mk(0,1,0,0,0,  0, 0, S_DOWN, 0, 0, 0,1));
        vecs.push_back(mk(0,0,0,0,0,  0, 0, S_IDLE, 0, 0, 0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.start = vecs[i].start; bus.stop = vecs[i].stop; bus.fault = vecs[i].fault;
            bus.fault_clr = vecs[i].clr; bus.carrier_wrap = vecs[i].wrap;
            bus.target_tw = TW_W'(vecs[i].ttw); bus.target_amp = AMP_W'(vecs[i].tamp);
            step();
            chk($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].st);
            chk($sformatf("vec%0d_tw", i), int'(bus.tune_word), vecs[i].tw);
            chk($sformatf("vec%0d_amp", i), int'(bus.amp), vecs[i].amp);
            chk($sformatf("vec%0d_cfg", i), int'(bus.cfg_update), vecs[i].cfg);
            chk($sformatf("vec%0d_en", i), int'(bus.pwm_en), vecs[i].en);
        end
        bus.fault = 1'b0;

        // Soft-start with a carrier wrap every 8 clocks
        bus.target_tw = 16'd40; bus.target_amp = 8'd24;
        bus.start = 1'b1;
        step();
        chk("ss_en", int'(bus.pwm_en), 1);
        chk("ss_state", int'(bus.state), S_UP);
        for (int w = 1; w <= 12; w++) begin
            wrap_after(8);
            if (w % 4 == 0) begin
                chk("ss_tw", int'(bus.tune_word), up_tw[w/4-1]);
                chk("ss_amp", int'(bus.amp), up_amp[w/4-1]);
                chk("ss_cfg", int'(bus.cfg_update), 1);
            end
        end
        step();
        chk("ss_run", int'(bus.state), S_RUN);

        // Soft-stop
        bus.stop = 1'b1;
        step();
        chk("sp_state", int'(bus.state), S_DOWN);
        for (int w = 1; w <= 12; w++) begin
            wrap_after(8);
            if (w % 4 == 0) begin
                chk("sp_tw", int'(bus.tune_word), dn_tw[w/4-1]);
                chk("sp_amp", int'(bus.amp), dn_amp[w/4-1]);
                chk("sp_cfg", int'(bus.cfg_update), 1);
            end
        end
        chk("sp_idle", int'(bus.state), S_IDLE);
        chk("sp_en", int'(bus.pwm_en), 0);

        // Run-tracking: lower amplitude target, clamped at the new goal
        bus.start = 1'b1;
        step();
        for (int w = 0; w < 12; w++) wrap_after(2);
        step();
        chk("trk_run", int'(bus.state), S_RUN);
        bus.target_amp = 8'd4;
        for (int w = 1; w <= 12; w++) begin
            wrap_after(2);
            if (w % 4 == 0) begin
                chk("trk_amp", int'(bus.amp), trk_amp[w/4-1]);
                chk("trk_tw", int'(bus.tune_word), 40);
                chk("trk_state", int'(bus.state), S_RUN);
            end
        end
        bus.stop = 1'b1;
        step();
        for (int i = 0; i < 64 && bus.state != 3'd0; i++) begin
            bus.carrier_wrap = 1'b1;
            step();
        end
        chk("trk_drain_idle", int'(bus.state), S_IDLE);

        // Reset mid-RAMP_UP
        bus.start = 1'b1;
        step();
        for (int w = 0; w < 4; w++) wrap_after(2);
        chk("rmu_tw", int'(bus.tune_word), 16);
        rst = 1'b1;
        step();
        chk("rmu_state", int'(bus.state), S_IDLE);
        chk("rmu_tw0", int'(bus.tune_word), 0);
        chk("rmu_amp0", int'(bus.amp), 0);
        chk("rmu_en0", int'(bus.pwm_en), 0);
        rst = 1'b0;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bus.start        = ($urandom_range(0, 14) == 0);
            bus.stop         = ($urandom_range(0, 39) == 0);
            bus.fault_clr    = ($urandom_range(0, 9) == 0);
            bus.carrier_wrap = ($urandom_range(0, 1) == 0);
            if (bus.fault) begin
                if ($urandom_range(0, 4) == 0) bus.fault = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                bus.fault = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) begin
                bus.target_tw  = ($urandom_range(0, 7) == 0) ? TW_W'($urandom_range(65400, 65535))
                                                             : TW_W'($urandom_range(0, 300));
                bus.target_amp = AMP_W'($urandom_range(0, 255));
            end
            rst = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
